// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D memory port arbiter.
// Holds the FSM state encoding, grant IDs and default bus widths.
package mem_arb_pkg;

   localparam int DEF_ADDR_W = 28;
   localparam int DEF_DATA_W = 128;
   localparam int STARVE_W   = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_I  = 2'd1,
      BUSY_D  = 2'd2,
      RELEASE = 2'd3
   } arb_state_e;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the I-cache and D-cache requesters.
// Fixed mode favours D unless I has waited STARVE_LIMIT grants; RR mode alternates.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int RR_MODE      = 0,
   parameter int STARVE_LIMIT = 4
)(
   input  logic                req_i,
   input  logic                req_d,
   input  grant_e              last_grant,
   input  logic [STARVE_W-1:0] starve_cnt,
   output grant_e              winner
);

   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   always_comb begin
      winner = GNT_I;
      if (req_d && !req_i) begin
         winner = GNT_D;
      end else if (req_d && req_i) begin
         if (RR_MODE != 0) begin
            winner = (last_grant == GNT_I) ? GNT_D : GNT_I;
         end else begin
            winner = (starve_cnt == STARVE_MAX) ? GNT_I : GNT_D;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single off-chip memory port between the I-cache and D-cache miss paths.
// One transaction at a time: grant, registered command, completion pulse, one release cycle.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int RR_MODE      = 0,
   parameter int STARVE_LIMIT = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic [DATA_W-1:0] i_mem_wdata,
   output logic [DATA_W-1:0] i_mem_rdata,
   output logic              i_mem_ready,
   input  logic              d_mem_read,
   input  logic              d_mem_write,
   input  logic [ADDR_W-1:0] d_mem_addr,
   input  logic [DATA_W-1:0] d_mem_wdata,
   output logic [DATA_W-1:0] d_mem_rdata,
   output logic              d_mem_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   arb_state_e          state_q, state_d;
   grant_e              last_grant_q, last_grant_d;
   grant_e              winner;
   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                i_ready_q, i_ready_d;
   logic                d_ready_q, d_ready_d;
   logic                req_i, req_d;

   assign req_i = i_mem_read | i_mem_write;
   assign req_d = d_mem_read | d_mem_write;

   mem_arb_pick #(
      .RR_MODE      (RR_MODE),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_pick (
      .req_i      (req_i),
      .req_d      (req_d),
      .last_grant (last_grant_q),
      .starve_cnt (starve_cnt_q),
      .winner     (winner)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      starve_cnt_d = starve_cnt_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      rdata_d      = rdata_q;
      i_ready_d    = 1'b0;
      d_ready_d    = 1'b0;

      case (state_q)
         IDLE: begin
            // A requester asserting both read and write is forwarded as a write only
            if (req_i || req_d) begin
               if (winner == GNT_D) begin
                  mem_write_d = d_mem_write;
                  mem_read_d  = d_mem_read & ~d_mem_write;
                  mem_addr_d  = d_mem_addr;
                  mem_wdata_d = d_mem_wdata;
                  state_d     = BUSY_D;
                  if (RR_MODE == 0) begin
                     if (!req_i) begin
                        starve_cnt_d = '0;
                     end else if (starve_cnt_q != STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                     end
                  end
               end else begin
                  mem_write_d  = i_mem_write;
                  mem_read_d   = i_mem_read & ~i_mem_write;
                  mem_addr_d   = i_mem_addr;
                  mem_wdata_d  = i_mem_wdata;
                  state_d      = BUSY_I;
                  starve_cnt_d = '0;
               end
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ready) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (mem_read_q) begin
                  rdata_d = mem_rdata;
               end
               if (state_q == BUSY_I) begin
                  i_ready_d    = 1'b1;
                  last_grant_d = GNT_I;
               end else begin
                  d_ready_d    = 1'b1;
                  last_grant_d = GNT_D;
               end
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= GNT_I;
         starve_cnt_q <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         rdata_q      <= '0;
         i_ready_q    <= 1'b0;
         d_ready_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         starve_cnt_q <= starve_cnt_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         rdata_q      <= rdata_d;
         i_ready_q    <= i_ready_d;
         d_ready_q    <= d_ready_d;
      end
   end

   assign i_mem_rdata = rdata_q;
   assign d_mem_rdata = rdata_q;
   assign i_mem_ready = i_ready_q;
   assign d_mem_ready = d_ready_q;
   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a fixed-priority and a round-robin instance,
// each driven by bench-side caches and memory and compared against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int AW    = 28;
   localparam int DW    = 128;
   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic rst;

   logic          i_rd [2], i_wr [2], d_rd [2], d_wr [2];
   logic [AW-1:0] i_addr [2], d_addr [2];
   logic [DW-1:0] i_wdata [2], d_wdata [2];
   logic [DW-1:0] i_rdata [2], d_rdata [2];
   logic          i_ready [2], d_ready [2];
   logic          mem_rd [2], mem_wr [2];
   logic [AW-1:0] mem_addr [2];
   logic [DW-1:0] mem_wdata [2], mem_rdata [2];
   logic          mem_ready [2];

   typedef struct {
      bit            pend;
      bit            granted;
      bit            rd;
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cache_t;

   typedef struct {
      bit            active;
      bit            owner_d;
      bit            wr;
      int            lat_left;
      int            gap;
      bit            last_d;
      int            streak;
      logic          rd_o;
      logic          wr_o;
      logic [AW-1:0] addr_o;
      logic [DW-1:0] wdata_o;
      logic [DW-1:0] rdata_o;
      logic          iready_o;
      logic          dready_o;
   } model_t;

   cache_t icache [2];
   cache_t dcache [2];
   model_t mdl [2];

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W (AW), .DATA_W (DW), .RR_MODE (0), .STARVE_LIMIT (LIMIT)
   ) dut_fixed (
      .clk (clk), .rst (rst),
      .i_mem_read (i_rd[0]), .i_mem_write (i_wr[0]), .i_mem_addr (i_addr[0]),
      .i_mem_wdata (i_wdata[0]), .i_mem_rdata (i_rdata[0]), .i_mem_ready (i_ready[0]),
      .d_mem_read (d_rd[0]), .d_mem_write (d_wr[0]), .d_mem_addr (d_addr[0]),
      .d_mem_wdata (d_wdata[0]), .d_mem_rdata (d_rdata[0]), .d_mem_ready (d_ready[0]),
      .mem_read (mem_rd[0]), .mem_write (mem_wr[0]), .mem_addr (mem_addr[0]),
      .mem_wdata (mem_wdata[0]), .mem_rdata (mem_rdata[0]), .mem_ready (mem_ready[0])
   );

   mem_port_arbiter #(
      .ADDR_W (AW), .DATA_W (DW), .RR_MODE (1), .STARVE_LIMIT (LIMIT)
   ) dut_rr (
      .clk (clk), .rst (rst),
      .i_mem_read (i_rd[1]), .i_mem_write (i_wr[1]), .i_mem_addr (i_addr[1]),
      .i_mem_wdata (i_wdata[1]), .i_mem_rdata (i_rdata[1]), .i_mem_ready (i_ready[1]),
      .d_mem_read (d_rd[1]), .d_mem_write (d_wr[1]), .d_mem_addr (d_addr[1]),
      .d_mem_wdata (d_wdata[1]), .d_mem_rdata (d_rdata[1]), .d_mem_ready (d_ready[1]),
      .mem_read (mem_rd[1]), .mem_write (mem_wr[1]), .mem_addr (mem_addr[1]),
      .mem_wdata (mem_wdata[1]), .mem_rdata (mem_rdata[1]), .mem_ready (mem_ready[1])
   );

   function automatic logic [DW-1:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic cache_t idleCache();
      cache_t c;
      c.pend = 1'b0; c.granted = 1'b0; c.rd = 1'b0; c.wr = 1'b0;
      c.addr = '0; c.wdata = '0;
      return c;
   endfunction

   function automatic model_t idleModel();
      model_t m;
      m.active = 1'b0; m.owner_d = 1'b0; m.wr = 1'b0; m.lat_left = 0; m.gap = 0;
      m.last_d = 1'b0; m.streak = 0;
      m.rd_o = 1'b0; m.wr_o = 1'b0; m.addr_o = '0; m.wdata_o = '0; m.rdata_o = '0;
      m.iready_o = 1'b0; m.dready_o = 1'b0;
      return m;
   endfunction

   // I-cache mostly reads; D-cache mixes reads, write-backs and the read+write corner
   function automatic cache_t newRequest(input bit is_d);
      cache_t c;
      int     sel;
      sel       = int'($urandom_range(0, 9));
      c.pend    = 1'b1;
      c.granted = 1'b0;
      if (is_d) begin
         c.rd = (sel < 5) || (sel > 7);
         c.wr = (sel >= 5);
      end else begin
         c.rd = (sel != 8);
         c.wr = (sel >= 8);
      end
      c.addr  = AW'($urandom());
      c.wdata = rand128();
      return c;
   endfunction

   // Once granted, a cache may wiggle its lines freely; the arbiter must ignore them
   function automatic cache_t busLines(input cache_t c);
      cache_t l;
      l = c;
      if (!c.pend || (c.granted && $urandom_range(0, 1) == 0)) begin
         l.rd    = c.pend ? 1'($urandom()) : 1'b0;
         l.wr    = c.pend ? 1'($urandom()) : 1'b0;
         l.addr  = AW'($urandom());
         l.wdata = rand128();
      end
      return l;
   endfunction

   task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   task automatic checkAll();
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("k%0d mem_read", k),  DW'(mem_rd[k]),    DW'(mdl[k].rd_o));
         checkOutput($sformatf("k%0d mem_write", k), DW'(mem_wr[k]),    DW'(mdl[k].wr_o));
         checkOutput($sformatf("k%0d mem_addr", k),  DW'(mem_addr[k]),  DW'(mdl[k].addr_o));
         checkOutput($sformatf("k%0d mem_wdata", k), mem_wdata[k],      mdl[k].wdata_o);
         checkOutput($sformatf("k%0d i_rdata", k),   i_rdata[k],        mdl[k].rdata_o);
         checkOutput($sformatf("k%0d d_rdata", k),   d_rdata[k],        mdl[k].rdata_o);
         checkOutput($sformatf("k%0d i_ready", k),   DW'(i_ready[k]),   DW'(mdl[k].iready_o));
         checkOutput($sformatf("k%0d d_ready", k),   DW'(d_ready[k]),   DW'(mdl[k].dready_o));
      end
   endtask

   // Chooses inputs for the coming edge and predicts the outputs right after it
   task automatic applyStimulus();
      for (int k = 0; k < 2; k++) begin
         logic          rdy;
         logic [DW-1:0] data;
         logic          req_i, req_d, pick_d, w;
         cache_t        li, ld;

         data = rand128();
         if (mdl[k].active) begin
            mdl[k].lat_left--;
            rdy = (mdl[k].lat_left == 0);
         end else begin
            rdy = ($urandom_range(0, 9) == 0);
         end
         mem_ready[k] = rdy;
         mem_rdata[k] = data;

         if (!icache[k].pend && $urandom_range(0, 99) < 60) icache[k] = newRequest(1'b0);
         if (!dcache[k].pend && $urandom_range(0, 99) < 70) dcache[k] = newRequest(1'b1);
         li = busLines(icache[k]);
         ld = busLines(dcache[k]);
         i_rd[k] = li.rd; i_wr[k] = li.wr; i_addr[k] = li.addr; i_wdata[k] = li.wdata;
         d_rd[k] = ld.rd; d_wr[k] = ld.wr; d_addr[k] = ld.addr; d_wdata[k] = ld.wdata;

         req_i = li.rd | li.wr;
         req_d = ld.rd | ld.wr;
         mdl[k].iready_o = 1'b0;
         mdl[k].dready_o = 1'b0;

         if (mdl[k].active) begin
            if (rdy) begin
               mdl[k].rd_o = 1'b0;
               mdl[k].wr_o = 1'b0;
               if (!mdl[k].wr) mdl[k].rdata_o = data;
               if (mdl[k].owner_d) begin
                  mdl[k].dready_o = 1'b1;
                  dcache[k].pend  = 1'b0;
               end else begin
                  mdl[k].iready_o = 1'b1;
                  icache[k].pend  = 1'b0;
               end
               mdl[k].last_d = mdl[k].owner_d;
               mdl[k].active = 1'b0;
               mdl[k].gap    = 1;
            end
         end else if (mdl[k].gap > 0) begin
            mdl[k].gap--;
         end else if (req_i || req_d) begin
            if (req_i && req_d) begin
               pick_d = (k == 1) ? !mdl[k].last_d : (mdl[k].streak != LIMIT);
            end else begin
               pick_d = req_d;
            end
            if (k == 0) begin
               if (pick_d && req_i) mdl[k].streak = (mdl[k].streak < LIMIT) ? mdl[k].streak + 1 : LIMIT;
               else                 mdl[k].streak = 0;
            end
            w                = pick_d ? ld.wr : li.wr;
            mdl[k].wr        = w;
            mdl[k].wr_o      = w;
            mdl[k].rd_o      = !w;
            mdl[k].addr_o    = pick_d ? ld.addr : li.addr;
            mdl[k].wdata_o   = pick_d ? ld.wdata : li.wdata;
            mdl[k].owner_d   = pick_d;
            mdl[k].active    = 1'b1;
            mdl[k].lat_left  = int'($urandom_range(1, 6));
            if (pick_d) dcache[k].granted = 1'b1;
            else        icache[k].granted = 1'b1;
         end
      end
   endtask

   task automatic quietInputs();
      for (int k = 0; k < 2; k++) begin
         i_rd[k] = 1'b0; i_wr[k] = 1'b0; i_addr[k] = '0; i_wdata[k] = '0;
         d_rd[k] = 1'b0; d_wr[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
         mem_ready[k] = 1'b0; mem_rdata[k] = '0;
         icache[k] = idleCache();
         dcache[k] = idleCache();
         mdl[k]    = idleModel();
      end
   endtask

   initial begin
      bit found;
      rst = 1'b1;
      quietInputs();

      @(negedge clk);
      checkAll();
      rst = 1'b0;
      applyStimulus();

      repeat (1500) begin
         @(negedge clk);
         checkAll();
         applyStimulus();
      end

      // Hunt for an outstanding D transaction, then reset in the middle of it
      found = 1'b0;
      for (int n = 0; n < 300 && !found; n++) begin
         @(negedge clk);
         checkAll();
         if (mdl[0].active && mdl[0].owner_d) found = 1'b1;
         else                                 applyStimulus();
      end
      checkOutput("reset_setup_busy_d", DW'(found), DW'(1'b1));

      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("k%0d async_rst mem_read", k),  DW'(mem_rd[k]),   '0);
         checkOutput($sformatf("k%0d async_rst mem_write", k), DW'(mem_wr[k]),   '0);
         checkOutput($sformatf("k%0d async_rst mem_addr", k),  DW'(mem_addr[k]), '0);
         checkOutput($sformatf("k%0d async_rst mem_wdata", k), mem_wdata[k],     '0);
         checkOutput($sformatf("k%0d async_rst rdata", k),     i_rdata[k],       '0);
         checkOutput($sformatf("k%0d async_rst i_ready", k),   DW'(i_ready[k]),  '0);
         checkOutput($sformatf("k%0d async_rst d_ready", k),   DW'(d_ready[k]),  '0);
      end
      quietInputs();

      @(negedge clk);
      checkAll();
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mem_ready[k] = 1'b1;
         mem_rdata[k] = rand128();
      end

      @(negedge clk);
      checkAll();
      applyStimulus();

      repeat (1500) begin
         @(negedge clk);
         checkAll();
         applyStimulus();
      end
      @(negedge clk);
      checkAll();

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single off-chip memory port between the I-cache miss path and the D-cache miss/write-back path of the pipelined MIPS core.
- Sits between the two cache controllers and the memory model.
- Accepts one transaction at a time, forwards it with registered command outputs, and returns read data plus a one-cycle ready pulse to the winning cache.
- Selects between fixed D-priority with anti-starvation and round-robin arbitration.

Parameters:
- ADDR_W, 28, memory line-address width.
- DATA_W, 128, memory line width in bits.
- RR_MODE, 0, 0 = fixed D-cache priority with starvation guard; 1 = round-robin.
- STARVE_LIMIT, 4, consecutive D grants allowed while I is pending before I is forced; legal range 1..15.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- i_mem_read  in  1  I-cache line read request (level, held until i_mem_ready)
- i_mem_write  in  1  I-cache write request; tied 0 in practice, still arbitrated
- i_mem_addr  in  ADDR_W  I-cache line address
- i_mem_wdata  in  DATA_W  I-cache write data
- i_mem_rdata  out  DATA_W  returned line (shared register rdata_q)
- i_mem_ready  out  1  one-cycle completion pulse to I-cache
- d_mem_read / d_mem_write / d_mem_addr / d_mem_wdata  in  1/1/ADDR_W/DATA_W  D-cache equivalents
- d_mem_rdata  out  DATA_W  returned line (same rdata_q)
- d_mem_ready  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  registered read command to memory
- mem_write  out  1  registered write command to memory
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completion, one cycle

Behaviour:
- Reset (asynchronous):
  - state=IDLE, and all outputs 0: mem_read, mem_write, mem_addr, mem_wdata, rdata_q, i_mem_ready, d_mem_ready.
  - last_grant=I, starve_cnt=0.
  - A reset mid-transaction abandons the transaction silently.
- Request: req_X = X_mem_read | X_mem_write. If both are set by one requester, the write wins and is forwarded as a write only.
- FSM states: IDLE, BUSY_I, BUSY_D, RELEASE.
- IDLE, no request: stay in IDLE, outputs 0.
- IDLE, at least one request:
  - Choose the winner:
    - If only one requester is active, it wins.
    - If both are active and RR_MODE=1, the one not equal to last_grant wins.
    - If both are active and RR_MODE=0, D wins unless starve_cnt==STARVE_LIMIT, in which case I wins.
  - On the same edge, latch the winner's read, write, addr and wdata into the mem_* registers and go to BUSY_X. The command is therefore visible one cycle after the request is sampled.
- BUSY_X:
  - Hold mem_* stable. Requester inputs are ignored; dropping a request mid-transaction does not abort it.
  - On the cycle mem_ready=1, clear mem_read and mem_write at that edge.
  - For a read, capture mem_rdata into rdata_q at that edge; for a write, rdata_q holds its previous value.
  - At that edge, set X_mem_ready=1 for exactly one cycle, set last_grant=X, and go to RELEASE.
- RELEASE:
  - Lasts exactly one cycle with ready low again.
  - Gives the cache one cycle to drop its level request, so a stale request is never re-granted.
  - Returns to IDLE.
- Latency: request seen in cycle 0 with the FSM in IDLE → mem command in cycle 1 → mem_ready in cycle k → X_mem_ready in cycle k+1 → IDLE in cycle k+2. The minimum back-to-back spacing between grants is 3 cycles plus the memory latency.
- starve_cnt (RR_MODE=0 only):
  - Increments on each D grant made while req_I=1.
  - Saturates at STARVE_LIMIT.
  - Clears on any I grant, and on any D grant made while req_I=0.
- mem_ready outside BUSY_I/BUSY_D is ignored; no state change.
- Only one of i_mem_ready/d_mem_ready is ever high in a cycle. mem_read and mem_write are never both high.

Decomposition:
- Shared package mem_arb_pkg:
  - State encodings IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2, RELEASE=2'd3.
  - Grant IDs GNT_I=1'b0, GNT_D=1'b1.
  - Default widths ADDR_W and DATA_W.
- One sub-module, mem_arb_pick: combinational winner select from req_I, req_D, last_grant, starve_cnt and RR_MODE.
- The starvation counter and FSM remain in the top module.

Test Plan:
- Single I read: i_mem_read=1, i_mem_addr=28'h0000040, memory answers 5 cycles later with 128'hA5..A5 → mem_read high in cycles 1–5, i_mem_ready pulse in cycle 6 with i_mem_rdata=128'hA5..A5, d_mem_ready stays 0.
- Simultaneous requests, RR_MODE=0: I read 28'h10 and D write 28'h20 (wdata=128'h1) both held → D granted first (mem_write=1, mem_addr=28'h20), then I (mem_read=1, mem_addr=28'h10).
- Starvation, RR_MODE=0, STARVE_LIMIT=4: I held, D re-requests continuously → exactly 4 D grants, then 1 I grant, then D again.
- Round-robin, RR_MODE=1: both requesters held continuously → grants alternate D, I, D, I after reset (last_grant=I).
- Both read and write set by D, addr 28'h30 → only mem_write=1 issued; after mem_ready, rdata_q unchanged.
- Reset asserted in BUSY_D mid-wait → all outputs 0 immediately; a later mem_ready causes no ready pulse; the next request is granted normally.
